// File: rtl/mc_control_unit.sv
// Multicycle MIPS control FSM with parametrised memory wait states, bne support
// and an exception path for illegal opcodes and arithmetic overflow.
module mc_control_unit #(
    parameter int MEM_WAIT   = 0,
    parameter int STATE_W    = 8,
    parameter int EXC_ON_OVF = 1
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [5:0]         Opcode,
    input  logic               Zero,
    input  logic               Overflow,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               BranchNe,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               MemtoReg,
    output logic               IRWrite,
    output logic               RegWrite,
    output logic               RegDst,
    output logic               EPCWrite,
    output logic [1:0]         PCSource,
    output logic [1:0]         ALUOp,
    output logic [1:0]         ALUSrcB,
    output logic               ALUSrcA,
    output logic [STATE_W-1:0] ControlState_Out
);
    localparam int CNT_W = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11,
        S_EXCEPTION = 4'd12
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_cyc;
    logic             mem_state;
    logic             ovf_exc;
    logic             unused_zero;

    // Zero only steers the PC-load condition, which the datapath evaluates.
    assign unused_zero = Zero;

    assign last_cyc  = (cnt_q == CNT_W'(MEM_WAIT));
    assign mem_state = (state_q == S_FETCH) || (state_q == S_MEM_READ) ||
                       (state_q == S_MEM_WRITE);
    assign ovf_exc   = Overflow && (EXC_ON_OVF != 0);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:     if (last_cyc) state_d = S_DECODE;
            S_DECODE: begin
                case (Opcode)
                    6'h00:        state_d = S_R_EXEC;
                    6'h23, 6'h2B: state_d = S_MEM_ADDR;
                    6'h04, 6'h05: state_d = S_BRANCH;
                    6'h02:        state_d = S_JUMP;
                    6'h08:        state_d = S_ADDI_EXEC;
                    default:      state_d = S_EXCEPTION;
                endcase
            end
            S_MEM_ADDR:  state_d = (Opcode == 6'h23) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  if (last_cyc) state_d = S_MEM_WB;
            S_MEM_WRITE: if (last_cyc) state_d = S_FETCH;
            S_R_EXEC:    state_d = ovf_exc ? S_EXCEPTION : S_R_WB;
            S_ADDI_EXEC: state_d = ovf_exc ? S_EXCEPTION : S_ADDI_WB;
            default:     state_d = S_FETCH;
        endcase
        // Any state change restarts the wait count for the next memory state.
        cnt_d = '0;
        if (mem_state && (state_d == state_q)) cnt_d = cnt_q + 1'b1;
    end

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        BranchNe    = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        EPCWrite    = 1'b0;
        PCSource    = 2'b00;
        ALUOp       = 2'b00;
        ALUSrcB     = 2'b00;
        ALUSrcA     = 1'b0;
        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = last_cyc;
                PCWrite = last_cyc;
            end
            S_DECODE:    ALUSrcB = 2'b11;
            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEM_READ: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEM_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_MEM_WRITE: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_R_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            S_R_WB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                BranchNe    = (Opcode == 6'h05);
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            S_ADDI_EXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_ADDI_WB:   RegWrite = 1'b1;
            S_EXCEPTION: begin
                EPCWrite = 1'b1;
                PCWrite  = 1'b1;
                PCSource = 2'b11;
            end
            default: ;
        endcase
    end

    assign ControlState_Out = STATE_W'(state_q);
endmodule
